col_parity_encoder: RTL and testbench

Streaming column-parity (Keccak-theta style) encoder for a 5×5×64 bit matrix stored as 64 slices of 25 bits in an external memory. It drives a slice address counter (`cnt_value`), reads each slice combinationally on `line_in`, and XORs every bit with the parity of two neighbouring columns. The parity comes from the current slice and the previous slice, with wrap-around. Each encoded slice is emitted as a one-cycle write strobe, and `donee` is raised after all 64 slices.

---
 rtl/col_parity_pkg.sv | 34 +++
 rtl/col_parity_theta_slice.sv | 38 +++
 rtl/col_parity_encoder.sv | 82 ++++++++
 tb/tb_col_parity_encoder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/col_parity_pkg.sv
// Shared widths, FSM state encoding and the column-parity helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package col_parity_pkg;

  localparam int LINE_W     = 25;
  localparam int NUM_SLICES = 64;
  localparam int CNT_W      = 7;
  localparam int IDX_W      = CNT_W - 1;   // bits actually used by the slice pointer

  // Pointer values: the memory presents slice (cnt_value+1) mod 64, so
  // 62 presents slice 63 and 63 presents slice 0.
  localparam logic [CNT_W-1:0] CNT_IDLE = 7'd62;
  localparam logic [CNT_W-1:0] CNT_PRE0 = 7'd63;
  localparam logic [CNT_W-1:0] CNT_LAST = 7'd62;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Column parity: bit x is the XOR of line[5*y+x] over y = 0..4.
  function automatic logic [4:0] col_parity(input logic [LINE_W-1:0] line);
    logic [4:0] par;
    par = '0;
    for (int y = 0; y < 5; y++) begin
      par = par ^ line[5*y +: 5];
    end
    return par;
  endfunction

endpackage

// File: rtl/col_parity_theta_slice.sv
// Theta step on one 25-bit slice: XOR each bit with the parities of its two neighbouring columns.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   line     - slice in, line[5*y+x] = A[x][y]
//   prev_par - column parity of the previous slice (z-1, wrapping)
//   enc_line - encoded slice
//   cur_par  - column parity of this slice, becomes prev_par for the next one
module col_parity_theta_slice
  import col_parity_pkg::*;
(
  input  logic [LINE_W-1:0] line,
  input  logic [4:0]        prev_par,
  output logic [LINE_W-1:0] enc_line,
  output logic [4:0]        cur_par
);

  logic [4:0] d_mask;

  assign cur_par = col_parity(line);

  always_comb begin
    d_mask = '0;
    for (int x = 0; x < 5; x++) begin
      d_mask[x] = cur_par[(x + 4) % 5] ^ prev_par[(x + 1) % 5];
    end
  end

  // The mask depends only on x, so every row gets the same 5-bit XOR.
  always_comb begin
    enc_line = '0;
    for (int y = 0; y < 5; y++) begin
      enc_line[5*y +: 5] = line[5*y +: 5] ^ d_mask;
    end
  end

endmodule

// File: rtl/col_parity_encoder.sv
// Streams 64 slices from memory through the theta step, one write strobe per slice, then raises donee.
// Latency: 128 cycles from the edge that samples start to donee; slice k strobes after edge 2k+1.
// Backpressure: none; the memory must answer combinationally and accept a write every other cycle.
//
// Ports:
//   clk, rst      - clock, asynchronous active-low reset
//   start         - level, sampled only in IDLE
//   cnt_value     - slice pointer; memory presents slice (cnt_value+1) mod 64 on line_in
//   line_in       - combinational slice data
//   write_enable  - one-cycle strobe, write_value valid while high
//   write_value   - registered encoded slice
//   donee         - pass complete, sticky until reset
module col_parity_encoder
  import col_parity_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [CNT_W-1:0]  cnt_value,
  input  logic [LINE_W-1:0] line_in,
  output logic              write_enable,
  output logic [LINE_W-1:0] write_value,
  output logic              donee
);

  state_t            state;
  logic [4:0]        prev_par;
  logic [LINE_W-1:0] enc_line;
  logic [4:0]        cur_par;

  col_parity_theta_slice u_theta (
    .line     (line_in),
    .prev_par (prev_par),
    .enc_line (enc_line),
    .cur_par  (cur_par)
  );

  // In IDLE the pointer presents slice 63, so its parity is captured on the
  // way out of IDLE and serves as the wrap-around neighbour of slice 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt_value   <= CNT_IDLE;
      prev_par    <= '0;
      write_value <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            prev_par  <= cur_par;
            cnt_value <= CNT_PRE0;
            state     <= LOAD;
          end
        end
        LOAD: begin
          write_value <= enc_line;
          prev_par    <= cur_par;
          state       <= WRITE;
        end
        WRITE: begin
          if (cnt_value == CNT_LAST) begin
            state <= DONE;
          end else begin
            // Bit 6 stays zero; the lower bits wrap 63 -> 0.
            cnt_value <= {1'b0, cnt_value[IDX_W-1:0] + IDX_W'(1)};
            state     <= LOAD;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign write_enable = (state == WRITE);
  assign donee        = (state == DONE);

endmodule

// File: tb/tb_col_parity_encoder.sv
// Self-checking bench for col_parity_encoder against a slice-level theta model.
// Latency: n/a.
// Backpressure: n/a.
module tb_col_parity_encoder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [6:0]  cnt_value;
  logic [24:0] line_in;
  logic        write_enable;
  logic [24:0] write_value;
  logic        donee;

  logic [24:0] mem     [64];
  logic [24:0] exp_out [64];
  logic [24:0] got_out [64];
  logic [5:0]  rd_idx;

  int n_assert = 0;
  int n_fail   = 0;

  col_parity_encoder dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cnt_value    (cnt_value),
    .line_in      (line_in),
    .write_enable (write_enable),
    .write_value  (write_value),
    .donee        (donee)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory answers combinationally with slice (cnt_value+1) mod 64.
  assign rd_idx  = cnt_value[5:0] + 6'd1;
  assign line_in = mem[rd_idx];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: A[x][y][z] = mem[z][5y+x]; C[z][x] = XOR_y A; out = A ^ C[z][x-1] ^ C[z-1][x+1].
  function automatic bit colpar(input int z, input int x);
    bit p = 0;
    for (int y = 0; y < 5; y++) p ^= mem[(z + 64) % 64][5*y + x];
    return p;
  endfunction

  task automatic build_model();
    for (int z = 0; z < 64; z++) begin
      for (int y = 0; y < 5; y++) begin
        for (int x = 0; x < 5; x++) begin
          exp_out[z][5*y + x] = mem[z][5*y + x] ^ colpar(z, (x + 4) % 5) ^ colpar(z - 1, (x + 1) % 5);
        end
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_cnt"},   32'(cnt_value),    32'd62);
    chk({tag, "_we"},    32'(write_enable), 32'd0);
    chk({tag, "_donee"}, 32'(donee),        32'd0);
    chk({tag, "_wval"},  32'(write_value),  32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Runs one pass from start, checking every cycle; abort_at > 0 pulls reset
  // right after that edge number and checks the outputs fall back at once.
  task automatic run_pass(input string tag, input int abort_at);
    int k;
    int nwr;
    logic [6:0] exp_cnt;
    build_model();
    nwr = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);                     // E0
    #2;
    chk({tag, "_cnt_e0"}, 32'(cnt_value), 32'd63);
    start = 1'($urandom_range(0, 1));   // level after E0 must not matter
    for (int i = 1; i <= 132; i++) begin
      @(posedge clk);
      #2;
      if (i % 7 == 0) start = 1'($urandom_range(0, 1));
      k = i / 2;
      exp_cnt = (k == 0) ? 7'd63 : ((k - 1 > 62) ? 7'd62 : 7'(k - 1));
      chk($sformatf("%s_we_E%0d", tag, i), 32'(write_enable), 32'((i % 2 == 1) && (i <= 127)));
      chk($sformatf("%s_donee_E%0d", tag, i), 32'(donee), 32'(i >= 128));
      chk($sformatf("%s_cnt_E%0d", tag, i), 32'(cnt_value), 32'(exp_cnt));
      if (write_enable === 1'b1 && nwr < 64) begin
        got_out[nwr] = write_value;
        chk($sformatf("%s_wval_s%0d", tag, nwr), 32'(write_value), 32'(exp_out[nwr]));
        nwr++;
      end
      if (abort_at > 0 && i == abort_at) begin
        rst = 1'b0;
        #1;
        check_reset_state({tag, "_abort"});
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        return;
      end
    end
    chk({tag, "_nwrites"}, 32'(nwr), 32'd64);
  endtask

  task automatic fill(input logic [24:0] v);
    for (int z = 0; z < 64; z++) mem[z] = v;
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    fill(25'h0);
    #12;
    check_reset_state("por");
    rst = 1'b1;

    // start held low: nothing moves
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i % 10 == 9) begin
        chk($sformatf("idle_cnt_%0d", i), 32'(cnt_value), 32'd62);
        chk($sformatf("idle_we_%0d", i), 32'(write_enable), 32'd0);
      end
    end

    // all-zero matrix
    run_pass("zero", 0);
    // start toggling after done: no further writes
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = ~start;
      chk($sformatf("post_we_%0d", i), 32'(write_enable), 32'd0);
      chk($sformatf("post_donee_%0d", i), 32'(donee), 32'd1);
    end

    // slice 0 bit 0
    do_reset();
    fill(25'h0);
    mem[0] = 25'h1;
    run_pass("s0b0", 0);
    chk("s0b0_w0", 32'(got_out[0]), 32'h0210843);
    chk("s0b0_w1", 32'(got_out[1]), 32'h1084210);
    chk("s0b0_w2", 32'(got_out[2]), 32'h0);

    // slice 63 bit 0, wrap-around
    do_reset();
    fill(25'h0);
    mem[63] = 25'h1;
    run_pass("s63b0", 0);
    chk("s63b0_w0",  32'(got_out[0]),  32'h1084210);
    chk("s63b0_w63", 32'(got_out[63]), 32'h0210843);
    chk("s63b0_w30", 32'(got_out[30]), 32'h0);

    // all ones: masks cancel
    do_reset();
    fill(25'h1FFFFFF);
    run_pass("ones", 0);
    chk("ones_w0",  32'(got_out[0]),  32'h1FFFFFF);
    chk("ones_w63", 32'(got_out[63]), 32'h1FFFFFF);

    // random matrices
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int z = 0; z < 64; z++) mem[z] = 25'($urandom);
      run_pass($sformatf("rand%0d", r), 0);
    end

    // reset right after the 10th write ends, then a full fresh pass
    do_reset();
    for (int z = 0; z < 64; z++) mem[z] = 25'($urandom);
    run_pass("abort", 20);
    @(negedge clk);
    check_reset_state("abort_idle");
    run_pass("after_abort", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
